miner_core: RTL and testbench
=============================

# miner_core

Proof-of-work search engine for the accelerator: the FSM, timer and hashcore behind the UART front end. Each round it:
- waits while the host loads a 76-byte block header;
- searches nonces with double SHA-256 for a fixed time window;
- keeps the lowest hash found and its nonce;
- hands control to the transmit side, which reads them out.

## Interface
Parameters:
- CLK_RATE, default 100_000: number of enabled clock cycles in one hash window (one "second").

Ports:
- clk, input, 1: sole clock, rising edge. One clock; reset is asynchronous and active-high.
- rst_i, input, 1: asynchronous, active-high reset.
- finished_recieving, input, 1: header fully loaded. Sampled only in READ.
- finished_sending, input, 1: result fully transmitted. Sampled only in WRITE.
- block_without_nonce, input, 608: header bytes 0..75. Byte i is at bits [8i+7:8i]. Must be stable while hash_enable=1.
- read_enable, output, 1: high in READ.
- hash_enable, output, 1: high in HASH.
- write_enable, output, 1: high in WRITE.
- second_tick, output, 1: one-cycle pulse at the end of the hash window.
- best_hash, output, 256: lowest digest of the current round.
- best_hash_nonce, output, 32: nonce that produced best_hash.

## Operation
FSM (Moore). Each state drives exactly one of the three enables high:
- READ: finished_recieving=1 → HASH.
- HASH: second_tick=1 → WRITE.
- WRITE: finished_sending=1 → READ.
- All other inputs are ignored in each state.
- Reset state is READ.

Timer:
- 32-bit counter. Increments each cycle while hash_enable=1; cleared to 0 whenever hash_enable=0.
- second_tick=1 in the cycle where the counter equals CLK_RATE-1; the counter then wraps to 0.

Hashcore, message construction:
- 80-byte message: block_without_nonce bytes 0..75, then the nonce little-endian as bytes 76..79.
- Bytes feed SHA-256 in index order; byte 0 is the MSB of W0.
- Digest D = SHA-256(SHA-256(message)).
- D is treated as a 256-bit unsigned value {H0,H1,...,H7}, H0 most significant.

Hashcore, single iterative SHA-256 compression engine:
- 64 rounds, one round per cycle.
- On-the-fly message schedule: 16-word shift register.

Hashcore, search sequence:
- On the rising edge of hash_enable: nonce←0, best_hash←all ones.
- Compress block 1 (bytes 0..63) once from IV → midstate.
- Per nonce, compress block 2 from the midstate: bytes 64..79, 0x80, zeros, 64-bit length 640.
- Then compress from IV the 32-byte digest, 0x80, zeros, length 256.
- If D < best_hash (strictly): best_hash←D, best_hash_nonce←nonce. Ties keep the earlier nonce.
- Nonce then increments by 1, wrapping 0xFFFFFFFF→0.

When hash_enable falls:
- Any in-flight nonce is abandoned and not compared.
- best_hash and best_hash_nonce hold until the next HASH entry, so WRITE can read them.

Reset (asynchronous, any time):
- FSM→READ, timer→0, nonce→0.
- best_hash←all ones, best_hash_nonce←0.
- Engine idle.

## Timing
- Each compression is 66 cycles: 1 load cycle, 64 rounds, 1 add/finalize cycle.
- Midstate completes 66 cycles after hash_enable rises.
- Nonce n is compared in the finalize cycle ending at 66+132(n+1) cycles after hash_enable rises. best_hash updates on that edge.
- FSM enables change on the clock edge after the qualifying input is sampled. No output cycle has zero or two enables high.
- The first second_tick occurs CLK_RATE cycles after hash_enable rises. hash_enable falls on the next edge.
- Reset values:
  - read_enable=1, hash_enable=0, write_enable=0, second_tick=0;
  - best_hash=256'hFF..FF, best_hash_nonce=0.

## Test plan
- Reset, then idle: read_enable=1, other enables 0, best_hash=all ones, best_hash_nonce=0. A finished_sending pulse in READ causes no transition.
- FSM cycle with CLK_RATE=10: finished_recieving pulse → hash_enable=1 next cycle. second_tick exactly 10 cycles later → write_enable. finished_sending → read_enable.
- Timer gating: hash_enable high for 5 cycles, then deasserted by reset → no tick. Next window ticks after a full 10 cycles.
- Hash correctness with CLK_RATE=66+132·4: header all zeros, then header with bytes = index. best_hash/best_hash_nonce equal the minimum over nonces 0..3 from a software SHA-256d model, exact 256/32-bit match.
- Abandoned nonce with CLK_RATE=66+132+60: only nonce 0 is compared. Result equals SHA-256d(header‖0x00000000) with nonce 0.
- Asynchronous reset mid-HASH: outputs return to reset values within the same cycle, with no clock edge required, and the FSM is in READ.

Source files
------------

// File: rtl/miner_core.sv
// Proof-of-work search core: READ/HASH/WRITE control, hash window timer
// and an iterative double SHA-256 engine tracking the lowest digest.
module miner_core #(
  parameter int CLK_RATE = 100_000
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         finished_recieving,
  input  logic         finished_sending,
  input  logic [607:0] block_without_nonce,
  output logic         read_enable,
  output logic         hash_enable,
  output logic         write_enable,
  output logic         second_tick,
  output logic [255:0] best_hash,
  output logic [31:0]  best_hash_nonce
);

  localparam logic [31:0] LAST = 32'(CLK_RATE - 1);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {ST_READ, ST_HASH, ST_WRITE} state_t;
  typedef enum logic [1:0] {S_LOAD, S_RND, S_FIN} step_t;
  typedef enum logic [1:0] {P_MID, P_B2, P_B3} phase_t;

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t        r_state;
  logic          r_rd;
  logic          r_hs;
  logic          r_wr;
  logic [31:0]   r_cnt;
  step_t         r_step;
  phase_t        r_phase;
  logic [5:0]    r_rnd;
  logic [31:0]   r_nonce;
  logic [31:0]   r_st   [8];
  logic [31:0]   r_base [8];
  logic [31:0]   r_mid  [8];
  logic [31:0]   r_dig  [8];
  logic [31:0]   r_w    [16];
  logic [255:0]  r_best;
  logic [31:0]   r_bnonce;

  logic          w_tick;
  logic          w_enter;
  logic [31:0]   w_hw   [19];
  logic [31:0]   w_init [8];
  logic [31:0]   w_blk  [16];
  logic [31:0]   w_sum  [8];
  logic [255:0]  w_sum_flat;
  logic [31:0]   w_t1;
  logic [31:0]   w_t2;
  logic [31:0]   w_wnew;

  assign w_tick  = r_hs && (r_cnt == LAST);
  assign w_enter = (r_state == ST_READ) && finished_recieving;

  assign read_enable     = r_rd;
  assign hash_enable     = r_hs;
  assign write_enable    = r_wr;
  assign second_tick     = w_tick;
  assign best_hash       = r_best;
  assign best_hash_nonce = r_bnonce;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_READ;
      r_rd    <= 1'b1;
      r_hs    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_READ: if (finished_recieving) begin
          r_state <= ST_HASH;
          r_rd    <= 1'b0;
          r_hs    <= 1'b1;
        end
        ST_HASH: if (w_tick) begin
          r_state <= ST_WRITE;
          r_hs    <= 1'b0;
          r_wr    <= 1'b1;
        end
        ST_WRITE: if (finished_sending) begin
          r_state <= ST_READ;
          r_wr    <= 1'b0;
          r_rd    <= 1'b1;
        end
        default: begin
          r_state <= ST_READ;
          r_rd    <= 1'b1;
          r_hs    <= 1'b0;
          r_wr    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)
      r_cnt <= '0;
    else if (!r_hs || w_tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 32'd1;
  end

  // Header bytes pack big-endian into schedule words
  always_comb begin
    for (int j = 0; j < 19; j++)
      w_hw[j] = {block_without_nonce[32*j +: 8],
                 block_without_nonce[32*j+8 +: 8],
                 block_without_nonce[32*j+16 +: 8],
                 block_without_nonce[32*j+24 +: 8]};
  end

  always_comb begin
    for (int i = 0; i < 8; i++) w_init[i] = IV[i];
    for (int j = 0; j < 16; j++) w_blk[j] = '0;
    unique case (r_phase)
      P_MID: begin
        for (int j = 0; j < 16; j++) w_blk[j] = w_hw[j];
      end
      P_B2: begin
        for (int i = 0; i < 8; i++) w_init[i] = r_mid[i];
        w_blk[0]  = w_hw[16];
        w_blk[1]  = w_hw[17];
        w_blk[2]  = w_hw[18];
        w_blk[3]  = {r_nonce[7:0], r_nonce[15:8],
                     r_nonce[23:16], r_nonce[31:24]};
        w_blk[4]  = 32'h8000_0000;
        w_blk[15] = 32'd640;
      end
      P_B3: begin
        for (int i = 0; i < 8; i++) w_blk[i] = r_dig[i];
        w_blk[8]  = 32'h8000_0000;
        w_blk[15] = 32'd256;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_t1 = r_st[7]
         + (rotr(r_st[4], 6) ^ rotr(r_st[4], 11) ^ rotr(r_st[4], 25))
         + ((r_st[4] & r_st[5]) ^ (~r_st[4] & r_st[6]))
         + K[r_rnd] + r_w[0];
    w_t2 = (rotr(r_st[0], 2) ^ rotr(r_st[0], 13) ^ rotr(r_st[0], 22))
         + ((r_st[0] & r_st[1]) ^ (r_st[0] & r_st[2])
            ^ (r_st[1] & r_st[2]));
    w_wnew = (rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10))
           + r_w[9]
           + (rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3))
           + r_w[0];
    for (int i = 0; i < 8; i++) w_sum[i] = r_base[i] + r_st[i];
    w_sum_flat = {w_sum[0], w_sum[1], w_sum[2], w_sum[3],
                  w_sum[4], w_sum[5], w_sum[6], w_sum[7]};
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_step   <= S_LOAD;
      r_phase  <= P_MID;
      r_rnd    <= '0;
      r_nonce  <= '0;
      r_best   <= '1;
      r_bnonce <= '0;
      for (int i = 0; i < 8; i++) begin
        r_st[i]   <= '0;
        r_base[i] <= '0;
        r_mid[i]  <= '0;
        r_dig[i]  <= '0;
      end
      for (int j = 0; j < 16; j++) r_w[j] <= '0;
    end else if (!r_hs) begin
      // Idle outside HASH; any half-done nonce is dropped here
      r_step  <= S_LOAD;
      r_phase <= P_MID;
      r_rnd   <= '0;
      r_nonce <= '0;
      if (w_enter) r_best <= '1;
    end else begin
      unique case (r_step)
        S_LOAD: begin
          for (int i = 0; i < 8; i++) begin
            r_st[i]   <= w_init[i];
            r_base[i] <= w_init[i];
          end
          for (int j = 0; j < 16; j++) r_w[j] <= w_blk[j];
          r_rnd  <= '0;
          r_step <= S_RND;
        end
        S_RND: begin
          r_st[0] <= w_t1 + w_t2;
          r_st[1] <= r_st[0];
          r_st[2] <= r_st[1];
          r_st[3] <= r_st[2];
          r_st[4] <= r_st[3] + w_t1;
          r_st[5] <= r_st[4];
          r_st[6] <= r_st[5];
          r_st[7] <= r_st[6];
          for (int j = 0; j < 15; j++) r_w[j] <= r_w[j+1];
          r_w[15] <= w_wnew;
          r_rnd   <= r_rnd + 6'd1;
          if (r_rnd == 6'd63) r_step <= S_FIN;
        end
        S_FIN: begin
          r_step <= S_LOAD;
          unique case (r_phase)
            P_MID: begin
              for (int i = 0; i < 8; i++) r_mid[i] <= w_sum[i];
              r_phase <= P_B2;
            end
            P_B2: begin
              for (int i = 0; i < 8; i++) r_dig[i] <= w_sum[i];
              r_phase <= P_B3;
            end
            P_B3: begin
              if (w_sum_flat < r_best) begin
                r_best   <= w_sum_flat;
                r_bnonce <= r_nonce;
              end
              r_nonce <= r_nonce + 32'd1;
              r_phase <= P_B2;
            end
            default: r_phase <= P_MID;
          endcase
        end
        default: r_step <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_miner_core.sv
// Directed + randomized bench for miner_core using a software SHA-256d model.
// Three instances cover the FSM/timer, full-window and abandoned-nonce cases.
module tb_miner_core;

  localparam logic [255:0] ONES = '1;
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic fr_a = 0, fs_a = 0, fr_b = 0, fs_b = 0, fr_c = 0, fs_c = 0;
  logic [607:0] hdr_a = '0, hdr_b = '0, hdr_c = '0;
  logic re_a, he_a, we_a, st_a;
  logic re_b, he_b, we_b, st_b;
  logic re_c, he_c, we_c, st_c;
  logic [255:0] bh_a, bh_b, bh_c;
  logic [31:0] bn_a, bn_b, bn_c;

  int checks = 0;
  int errors = 0;

  miner_core #(.CLK_RATE(10)) u_a (
    .clk(clk), .rst_i(rst),
    .finished_recieving(fr_a), .finished_sending(fs_a),
    .block_without_nonce(hdr_a),
    .read_enable(re_a), .hash_enable(he_a), .write_enable(we_a),
    .second_tick(st_a), .best_hash(bh_a), .best_hash_nonce(bn_a));

  miner_core #(.CLK_RATE(66 + 132 * 4)) u_b (
    .clk(clk), .rst_i(rst),
    .finished_recieving(fr_b), .finished_sending(fs_b),
    .block_without_nonce(hdr_b),
    .read_enable(re_b), .hash_enable(he_b), .write_enable(we_b),
    .second_tick(st_b), .best_hash(bh_b), .best_hash_nonce(bn_b));

  miner_core #(.CLK_RATE(66 + 132 + 60)) u_c (
    .clk(clk), .rst_i(rst),
    .finished_recieving(fr_c), .finished_sending(fs_c),
    .block_without_nonce(hdr_c),
    .read_enable(re_c), .hash_enable(he_c), .write_enable(we_c),
    .second_tick(st_c), .best_hash(bh_c), .best_hash_nonce(bn_c));

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(
    input logic [255:0] hin,
    input logic [511:0] blk
  );
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10))
           + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
           + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++)
      compress[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
  endfunction

  // Whole 80-byte message padded into two blocks, then hashed again
  function automatic logic [255:0] sha256d(
    input logic [607:0] hdr,
    input logic [31:0]  nonce
  );
    logic [1023:0] m;
    logic [255:0]  h1;
    m = '0;
    for (int i = 0; i < 76; i++) m[1023 - 8*i -: 8] = hdr[8*i +: 8];
    for (int i = 0; i < 4; i++) m[1023 - 8*(76+i) -: 8] = nonce[8*i +: 8];
    m[1023 - 8*80 -: 8] = 8'h80;
    m[63:0] = 64'd640;
    h1 = compress(compress(IV, m[1023:512]), m[511:0]);
    return compress(IV, {h1, 8'h80, 184'b0, 64'd256});
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_b(input logic [607:0] h, input string tag);
    logic [255:0] best, d, d0;
    logic [31:0]  bn;
    int ticks;
    best = ONES; bn = '0; ticks = 0;
    for (int n = 0; n < 4; n++) begin
      d = sha256d(h, 32'(n));
      if (n == 0) d0 = d;
      if (d < best) begin best = d; bn = 32'(n); end
    end
    hdr_b = h;
    fr_b = 1; step(1); fr_b = 0;
    chk({tag, "_he"}, 256'(he_b), 256'(1));
    chk({tag, "_best_init"}, bh_b, ONES);
    for (int c = 1; c <= 594; c++) begin
      if (c == 198) chk({tag, "_pre_n0"}, bh_b, ONES);
      if (c == 199) chk({tag, "_post_n0"}, bh_b, d0);
      if (st_b) ticks++;
      step(1);
    end
    chk({tag, "_we"}, 256'(we_b), 256'(1));
    chk({tag, "_ticks"}, 256'(ticks), 256'(1));
    chk({tag, "_best"}, bh_b, best);
    chk({tag, "_nonce"}, 256'(bn_b), 256'(bn));
    fs_b = 1; step(1); fs_b = 0;
    chk({tag, "_re"}, 256'(re_b), 256'(1));
  endtask

  initial begin
    logic [607:0] h;
    logic [255:0] d0;
    int ticks;

    chk("model_abc",
        compress(IV, {24'h616263, 8'h80, 416'b0, 64'd24}),
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    step(3);
    rst = 0;
    step(1);
    chk("rst_re", 256'({re_a, re_b, re_c}), 256'(3'b111));
    chk("rst_he", 256'({he_a, he_b, he_c}), 256'(0));
    chk("rst_we", 256'({we_a, we_b, we_c}), 256'(0));
    chk("rst_tick", 256'({st_a, st_b, st_c}), 256'(0));
    chk("rst_best", bh_a & bh_b & bh_c, ONES);
    chk("rst_nonce", 256'(bn_a | bn_b | bn_c), 256'(0));

    fs_a = 1; step(1); fs_a = 0;
    chk("read_ignore_fs", 256'({re_a, he_a, we_a}), 256'(3'b100));
    step($urandom_range(1, 5));

    fr_a = 1; step(1); fr_a = 0;
    chk("fsm_hash", 256'({re_a, he_a, we_a}), 256'(3'b010));
    ticks = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) chk("tick_at_10", 256'(st_a), 256'(1));
      else if (st_a) ticks++;
      step(1);
    end
    chk("tick_early", 256'(ticks), 256'(0));
    chk("fsm_write", 256'({re_a, he_a, we_a}), 256'(3'b001));
    fr_a = 1; step(1); fr_a = 0;
    chk("write_ignore_fr", 256'({re_a, he_a, we_a}), 256'(3'b001));
    fs_a = 1; step(1); fs_a = 0;
    chk("fsm_read", 256'({re_a, he_a, we_a}), 256'(3'b100));

    fr_a = 1; step(1); fr_a = 0;
    ticks = 0;
    for (int c = 1; c <= 5; c++) begin
      if (st_a) ticks++;
      step(1);
    end
    chk("gate_no_tick", 256'(ticks), 256'(0));
    rst = 1; #1;
    chk("gate_rst", 256'({re_a, he_a, we_a, st_a}), 256'(4'b1000));
    step(1); rst = 0; step(1);
    fr_a = 1; step(1); fr_a = 0;
    ticks = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) chk("gate_tick_10", 256'(st_a), 256'(1));
      else if (st_a) ticks++;
      step(1);
    end
    chk("gate_tick_early", 256'(ticks), 256'(0));
    chk("gate_write", 256'(we_a), 256'(1));

    h = '0;
    run_b(h, "hz");
    for (int i = 0; i < 76; i++) h[8*i +: 8] = 8'(i);
    run_b(h, "hi");
    for (int i = 0; i < 19; i++) h[32*i +: 32] = $urandom();
    run_b(h, "hr");

    for (int i = 0; i < 19; i++) h[32*i +: 32] = $urandom();
    d0 = sha256d(h, 32'd0);
    hdr_c = h;
    fr_c = 1; step(1); fr_c = 0;
    step(258);
    chk("ab_we", 256'(we_c), 256'(1));
    chk("ab_best", bh_c, d0);
    chk("ab_nonce", 256'(bn_c), 256'(0));
    fs_c = 1; step(1); fs_c = 0;

    for (int i = 0; i < 19; i++) h[32*i +: 32] = $urandom();
    d0 = sha256d(h, 32'd0);
    hdr_c = h;
    fr_c = 1; step(1); fr_c = 0;
    step(249);
    chk("ar_pre_best", bh_c, d0);
    rst = 1; #1;
    chk("ar_enables", 256'({re_c, he_c, we_c, st_c}), 256'(4'b1000));
    chk("ar_best", bh_c, ONES);
    chk("ar_nonce", 256'(bn_c), 256'(0));
    step(1); rst = 0; step(1);
    chk("ar_idle", 256'({re_c, he_c, we_c}), 256'(3'b100));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
